// File: rtl/score_text_writer.sv
// Writes one 4-character ASCII field (th, hu, te, on) into a text buffer at consecutive addresses.
// Optional LEADING_ZERO_BLANK_EN: leading '0' characters (except the ones digit) are captured as spaces.
module score_text_writer #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [7:0]        char_th,
    input  logic [7:0]        char_hu,
    input  logic [7:0]        char_te,
    input  logic [7:0]        char_on,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [1:0] LAST_IDX    = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [1:0]        idx, idx_nxt, idx_inc;
    logic [3:0][7:0]   snap, snap_nxt;
    logic [3:0][7:0]   fld;
    logic [ADDR_W-1:0] snap_base, snap_base_nxt;
    logic              wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [7:0]        wr_data_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    // Characters as they will be captured; slot 0 is the most significant digit.
`ifdef LEADING_ZERO_BLANK_EN
    logic lead_th, lead_hu, lead_te;
    always_comb begin
        lead_th = (char_th == ASCII_ZERO);
        lead_hu = lead_th && (char_hu == ASCII_ZERO);
        lead_te = lead_hu && (char_te == ASCII_ZERO);
        fld[0]  = lead_th ? ASCII_SPACE : char_th;
        fld[1]  = lead_hu ? ASCII_SPACE : char_hu;
        fld[2]  = lead_te ? ASCII_SPACE : char_te;
        fld[3]  = char_on;
    end
`else
    always_comb begin
        fld[0] = char_th;
        fld[1] = char_hu;
        fld[2] = char_te;
        fld[3] = char_on;
    end
`endif

    assign idx_inc = 2'(idx + 2'd1);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        snap_nxt      = snap;
        snap_base_nxt = snap_base;
        wr_en_nxt     = wr_en;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        busy_nxt      = busy;
        done_nxt      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    snap_nxt      = fld;
                    snap_base_nxt = base_addr;
                    idx_nxt       = 2'd0;
                    wr_en_nxt     = 1'b1;
                    wr_addr_nxt   = base_addr;
                    wr_data_nxt   = fld[0];
                    busy_nxt      = 1'b1;
                    state_nxt     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Address/data only advance on an accepted write, so stalls hold them.
                if (wr_ready) begin
                    idx_nxt = idx_inc;
                    if (idx == LAST_IDX) begin
                        wr_en_nxt = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        wr_addr_nxt = snap_base + ADDR_W'(idx_inc);
                        wr_data_nxt = snap[idx_inc];
                    end
                end
            end
            ST_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                wr_en_nxt = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            snap      <= '0;
            snap_base <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            snap      <= snap_nxt;
            snap_base <= snap_base_nxt;
            wr_en     <= wr_en_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_score_text_writer.sv
// Directed self-checking bench for score_text_writer; expected values are hand-computed.
// Expected blanking results follow LEADING_ZERO_BLANK_EN when compiled with it.
module tb_score_text_writer;

    logic        Clk;
    logic        Reset_n;
    logic        start;
    logic [7:0]  char_th, char_hu, char_te, char_on;
    logic [11:0] base_addr;
    logic        wr_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int wr_cnt  = 0;
    int done_cnt = 0;
    int wr_base, done_base;

    score_text_writer #(.ADDR_W(12)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .char_th   (char_th),
        .char_hu   (char_hu),
        .char_te   (char_te),
        .char_on   (char_on),
        .base_addr (base_addr),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count accepted writes and done pulses, sampled mid-cycle.
    always @(negedge Clk) begin
        if (wr_en && wr_ready) wr_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each expect_* samples the current cycle at negedge, then moves to 1 time unit past the next posedge.
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_wr(input string tag, input logic [11:0] a, input logic [7:0] d);
        @(negedge Clk);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'd1);
        chk({tag, ".addr"}, 32'(wr_addr), 32'(a));
        chk({tag, ".data"}, 32'(wr_data), 32'(d));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".done"}, 32'(done), 32'd0);
        next_cycle();
    endtask

    task automatic expect_done(input string tag);
        @(negedge Clk);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".done"}, 32'(done), 32'd1);
        next_cycle();
    endtask

    task automatic expect_idle(input string tag);
        @(negedge Clk);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        next_cycle();
    endtask

    task automatic set_chars(input logic [7:0] t, input logic [7:0] h, input logic [7:0] e, input logic [7:0] o);
        char_th = t;
        char_hu = h;
        char_te = e;
        char_on = o;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, ".addr"}, 32'(wr_addr), 32'd0);
        chk({tag, ".data"}, 32'(wr_data), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
    endtask

    // Full field with wr_ready high: start in cycle 0, writes 1-4, done 5, idle 6.
    task automatic run_field(input string tag, input logic [11:0] b,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        base_addr = b;
        wr_ready  = 1'b1;
        start     = 1'b1;
        expect_idle({tag, ".c0"});
        start     = 1'b0;
        expect_wr({tag, ".w0"}, b, d0);
        expect_wr({tag, ".w1"}, 12'(b + 12'd1), d1);
        expect_wr({tag, ".w2"}, 12'(b + 12'd2), d2);
        expect_wr({tag, ".w3"}, 12'(b + 12'd3), d3);
        expect_done({tag, ".done"});
        expect_idle({tag, ".c6"});
    endtask

    initial begin
        Reset_n   = 1'b0;
        start     = 1'b0;
        wr_ready  = 1'b1;
        base_addr = 12'h000;
        set_chars(8'h00, 8'h00, 8'h00, 8'h00);
        next_cycle();
        next_cycle();
        check_zero("reset");
        Reset_n = 1'b1;
        next_cycle();

        // "1A2F" at 0x100, ready high.
        set_chars(8'h31, 8'h41, 8'h32, 8'h46);
        wr_base = wr_cnt;
        done_base = done_cnt;
        run_field("basic", 12'h100, 8'h31, 8'h41, 8'h32, 8'h46);
        chk("basic.wr_cnt", 32'(wr_cnt - wr_base), 32'd4);
        chk("basic.done_cnt", 32'(done_cnt - done_base), 32'd1);

        // Stall: wr_ready low during cycles 2-4.
        wr_base = wr_cnt;
        done_base = done_cnt;
        base_addr = 12'h100;
        start = 1'b1;
        expect_idle("stall.c0");
        start = 1'b0;
        expect_wr("stall.w0", 12'h100, 8'h31);
        wr_ready = 1'b0;
        expect_wr("stall.h1", 12'h101, 8'h41);
        expect_wr("stall.h2", 12'h101, 8'h41);
        expect_wr("stall.h3", 12'h101, 8'h41);
        wr_ready = 1'b1;
        expect_wr("stall.w1", 12'h101, 8'h41);
        expect_wr("stall.w2", 12'h102, 8'h32);
        expect_wr("stall.w3", 12'h103, 8'h46);
        expect_done("stall.done");
        expect_idle("stall.c9");
        chk("stall.wr_cnt", 32'(wr_cnt - wr_base), 32'd4);
        chk("stall.done_cnt", 32'(done_cnt - done_base), 32'd1);

        // Address wrap from 0xFFE.
        run_field("wrap", 12'hFFE, 8'h31, 8'h41, 8'h32, 8'h46);

        // Leading-zero handling.
        set_chars(8'h30, 8'h30, 8'h30, 8'h35);
`ifdef LEADING_ZERO_BLANK_EN
        run_field("z0005", 12'h010, 8'h20, 8'h20, 8'h20, 8'h35);
`else
        run_field("z0005", 12'h010, 8'h30, 8'h30, 8'h30, 8'h35);
`endif
        set_chars(8'h30, 8'h30, 8'h30, 8'h30);
`ifdef LEADING_ZERO_BLANK_EN
        run_field("z0000", 12'h020, 8'h20, 8'h20, 8'h20, 8'h30);
`else
        run_field("z0000", 12'h020, 8'h30, 8'h30, 8'h30, 8'h30);
`endif
        set_chars(8'h30, 8'h41, 8'h30, 8'h30);
`ifdef LEADING_ZERO_BLANK_EN
        run_field("z0A00", 12'h030, 8'h20, 8'h41, 8'h30, 8'h30);
`else
        run_field("z0A00", 12'h030, 8'h30, 8'h41, 8'h30, 8'h30);
`endif

        // Reset after the second write abandons the field.
        set_chars(8'h31, 8'h41, 8'h32, 8'h46);
        done_base = done_cnt;
        base_addr = 12'h100;
        start = 1'b1;
        expect_idle("rst.c0");
        start = 1'b0;
        expect_wr("rst.w0", 12'h100, 8'h31);
        expect_wr("rst.w1", 12'h101, 8'h41);
        Reset_n = 1'b0;
        #1;
        check_zero("rst.async");
        next_cycle();
        next_cycle();
        check_zero("rst.hold");
        Reset_n = 1'b1;
        next_cycle();
        chk("rst.no_done", 32'(done_cnt - done_base), 32'd0);
        wr_base = wr_cnt;
        run_field("rst.new", 12'h200, 8'h31, 8'h41, 8'h32, 8'h46);
        chk("rst.new.wr_cnt", 32'(wr_cnt - wr_base), 32'd4);
        chk("rst.new.done_cnt", 32'(done_cnt - done_base), 32'd1);

        // start held high; inputs change mid-field and must not leak in.
        set_chars(8'h31, 8'h41, 8'h32, 8'h46);
        base_addr = 12'h100;
        start = 1'b1;
        expect_idle("hold.c0");
        set_chars(8'h39, 8'h38, 8'h37, 8'h36);
        base_addr = 12'h200;
        expect_wr("hold.w0", 12'h100, 8'h31);
        expect_wr("hold.w1", 12'h101, 8'h41);
        expect_wr("hold.w2", 12'h102, 8'h32);
        expect_wr("hold.w3", 12'h103, 8'h46);
        expect_done("hold.done");
        expect_idle("hold.c6");
        expect_wr("hold.n0", 12'h200, 8'h39);
        start = 1'b0;
        expect_wr("hold.n1", 12'h201, 8'h38);
        expect_wr("hold.n2", 12'h202, 8'h37);
        expect_wr("hold.n3", 12'h203, 8'h36);
        expect_done("hold.ndone");
        expect_idle("hold.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
